// File: rtl/shift_sequencer_if.sv
// Interface for the shift sequencer: request handshake, barrel-shifter drive
// and capture, and the result handshake toward the ALU result path.
interface shift_sequencer_if;
   logic        inValid;
   logic        inReady;
   logic [15:0] operand;
   logic [3:0]  amount;
   logic [15:0] shBitsIn;
   logic        shSel1;
   logic        shSel2;
   logic [15:0] shBitsOut;
   logic        outValid;
   logic        outReady;
   logic [15:0] result;
   logic        carry;
   logic        zero;

   // Environment side: issues requests, hosts the barrel shifter, consumes results.
   modport master (
      output inValid, operand, amount, shBitsOut, outReady,
      input  inReady, shBitsIn, shSel1, shSel2, outValid, result, carry, zero
   );

   // Sequencer side.
   modport slave (
      input  inValid, operand, amount, shBitsOut, outReady,
      output inReady, shBitsIn, shSel1, shSel2, outValid, result, carry, zero
   );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-pass 16-bit logical-left-shift controller. Feeds an external
// 0..3-bit-per-pass barrel shifter, recaptures its output each cycle and
// repeats until the requested amount is consumed, then offers the result,
// carry-out and zero flag through a valid/ready handshake.
module shift_sequencer (
   input  logic            clk,
   input  logic            reset,
   shift_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] work_reg, work_next;
   logic [3:0]  remaining_reg, remaining_next;
   logic        carry_reg, carry_next;
   logic [1:0]  step;
   logic [1:0]  sel;
   logic        carry_bit;

   // Per-pass distance: up to 3 bits, or whatever is left when fewer remain.
   always_comb begin
      step = 2'd3;
      if (remaining_reg < 4'd3) begin
         step = remaining_reg[1:0];
      end
   end

   // Bit that leaves the top of the word during this pass (pre-step work[16-step]).
   always_comb begin
      carry_bit = 1'b0;
      case (step)
         2'd1:    carry_bit = work_reg[15];
         2'd2:    carry_bit = work_reg[14];
         2'd3:    carry_bit = work_reg[13];
         default: carry_bit = 1'b0;
      endcase
   end

   // Next-state and datapath update; shifter selects are live only while shifting.
   always_comb begin
      state_next     = state_reg;
      work_next      = work_reg;
      remaining_next = remaining_reg;
      carry_next     = carry_reg;
      sel            = 2'b00;
      case (state_reg)
         IDLE: begin
            if (bus.inValid && bus.inReady) begin
               work_next      = bus.operand;
               remaining_next = bus.amount;
               carry_next     = 1'b0;
               state_next     = (bus.amount != 4'd0) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            sel            = step;
            work_next      = bus.shBitsOut;
            carry_next     = carry_bit;
            remaining_next = remaining_reg - {2'b00, step};
            if (remaining_next == 4'd0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (bus.outReady) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         work_reg      <= 16'h0000;
         remaining_reg <= 4'd0;
         carry_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         work_reg      <= work_next;
         remaining_reg <= remaining_next;
         carry_reg     <= carry_next;
      end
   end

   assign bus.inReady  = (state_reg == IDLE) && !reset;
   assign bus.shBitsIn = work_reg;
   assign bus.shSel1   = sel[0];
   assign bus.shSel2   = sel[1];
   assign bus.outValid = (state_reg == DONE);
   assign bus.result   = work_reg;
   assign bus.carry    = carry_reg;
   assign bus.zero     = (state_reg == DONE) && (work_reg == 16'h0000);

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-pass controller for 16-bit logical left shifts (LSL) by 0–15 bits. It sits directly upstream of the two-stage barrel shifter, which shifts by 0–3 bits per pass. It drives that shifter's data and select inputs, captures the shifter's output every cycle, and repeats until the requested amount is consumed. It then presents the result, carry-out and zero flag to the ALU result path through a valid/ready handshake.

## Interface
Parameters:
- none (data width fixed at 16, shift amount fixed at 4 bits)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- inValid  in  1  request: operand/amount are valid
- inReady  out  1  sequencer can accept a request
- operand  in  16  value to shift
- amount  in  4  shift distance, 0–15
- shBitsIn  out  16  data to barrel shifter
- shSel1  out  1  barrel shifter shift-by-1 select
- shSel2  out  1  barrel shifter shift-by-2 select
- shBitsOut  in  16  barrel shifter result; combinational from shBitsIn/shSel1/shSel2 within the same cycle
- outValid  out  1  result/carry/zero valid
- outReady  in  1  consumer accepts result
- result  out  16  shifted value
- carry  out  1  last bit shifted out (0 if amount = 0)
- zero  out  1  result == 0

## Operation
Registers:
- state ∈ {IDLE, SHIFT, DONE}
- work[15:0], remaining[3:0], carry

Per-cycle step in SHIFT: step = min(remaining, 3).

Combinational outputs:
- inReady = (state == IDLE) && !reset.
- shBitsIn = work at all times.
- shSel1 = step[0] and shSel2 = step[1] in SHIFT only; both 0 in IDLE and DONE.
- outValid = (state == DONE).
- result = work.
- zero = (work == 16'h0000), qualified by outValid.

IDLE:
- On inValid && inReady: work ← operand, remaining ← amount, carry ← 0.
- Next state is SHIFT if amount ≠ 0, otherwise DONE.

SHIFT:
- Each edge: work ← shBitsOut, carry ← work[16 − step] (pre-step value), remaining ← remaining − step.
- Next state is DONE when remaining − step == 0, otherwise stay in SHIFT.
- Step sequence: 3,3,…,3 then remaining mod 3 if nonzero. Example: amount 5 gives steps 3, 2.

DONE:
- Hold work and carry.
- On outReady go to IDLE; otherwise stay in DONE with all outputs stable.

General rules:
- inValid is ignored outside IDLE; no queuing.
- Width rule: bits shifted past bit 15 are discarded and vacated LSBs are 0. The final result equals (operand << amount) truncated to 16 bits.
- The carry flag equals operand[16 − amount] for amount ≥ 1.

Reset (asynchronous, any state, including mid-SHIFT):
- state ← IDLE, work ← 0, remaining ← 0, carry ← 0.
- Outputs take effect immediately: outValid = 0, result = 0, shSel1 = shSel2 = 0, inReady = 0 while reset is high.
- Any in-flight operation is discarded.

## Timing
- Accept edge E0: inValid && inReady sampled high.
- SHIFT occupies cycles E0→E1 … E(k−1)→Ek, where k = ceil(amount/3), so k ≤ 5.
- outValid rises after edge Ek (after E0 when amount = 0). Latency is 0–5 cycles from E0.
- Result handoff occurs on the edge where outValid && outReady. inReady returns high the cycle after handoff.
- Minimum request spacing: k + 2 cycles.
- No combinational path from inValid to outValid, or from outReady to inReady.

## Test plan
1. Reset, then operand 0x0003, amount 3 → exactly one SHIFT cycle with shSel1 = shSel2 = 1. Then outValid = 1 after E1, result 0x0018, carry 0, zero 0.
2. Operand 0x8001, amount 1 → one SHIFT cycle with shSel1 = 1, shSel2 = 0. Then result 0x0002, carry 1.
3. Operand 0xFFFF, amount 15 → five SHIFT cycles each with step 3. outValid after E5, result 0x8000, carry 1. Hold outReady = 0 for 3 cycles while pulsing inValid: outputs stay stable, inReady stays 0, no request is accepted.
4. Operand 0x1234, amount 0 → no SHIFT cycle, shSel1/shSel2 stay 0. outValid after E0, result 0x1234, carry 0.
5. Operand 0x0100, amount 8 → steps 3, 3, 2 with work values 0x0800, 0x4000, 0x0000. Result 0x0000, zero 1, carry 1. Operand 0x0401, amount 5 → result 0x8020, carry 0.
6. Operand 0xFFFF, amount 15; assert reset during the 2nd SHIFT cycle → outValid 0, result 0x0000, shSel1 = shSel2 = 0 immediately. After release inReady = 1, and a new request (0x0003, amount 2) returns 0x000C, carry 0.
